// File: rtl/filt_pkg.sv
// Shared definitions for the filter-bank sequencer: FSM state type and
// default geometry constants.
package filt_pkg;

  localparam int unsigned TAPS_DEFAULT  = 1023;
  localparam int unsigned PTR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } filt_state_e;

endpackage

// File: rtl/filt_sequencer.sv
// Filter-bank sequencer: writes incoming sample pairs into a circular queue
// and, once TAPS samples are held, sweeps rd_ptr over the TAPS+1 window for
// the accumulating filter bank, then strobes capt for one cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   smpl_valid   one-cycle strobe: new sample pair available
//   wr_en        queue write strobe (equals smpl_valid)
//   wr_ptr       queue write address
//   rd_ptr       queue read address to the filter bank
//   sequencing   high while the filter bank accumulates (RUN)
//   capt         one-cycle strobe: filter outputs valid (CAPT)
//   busy         high in RUN or CAPT
//   ovr_cnt      lost-start counter, only when FILT_SEQ_OVR_EN is defined
module filt_sequencer
  import filt_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEFAULT,
  parameter int unsigned PTR_W = PTR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_valid,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             sequencing,
  output logic             capt,
  output logic             busy
`ifdef FILT_SEQ_OVR_EN
  ,
  output logic [7:0]       ovr_cnt
`endif
);

  localparam logic [PTR_W-1:0] TAPS_P = PTR_W'(TAPS);
  localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);

  filt_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] tap_q, tap_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic             pend_q, pend_d;
  logic             seq_q, capt_q, busy_q;
  logic             start_run;

  assign wr_en      = smpl_valid;
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign sequencing = seq_q;
  assign capt       = capt_q;
  assign busy       = busy_q;

  // Next-state, pointer and counter logic.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = smpl_valid ? wr_ptr_q + ONE_P : wr_ptr_q;
    fill_d    = (smpl_valid && (fill_q != TAPS_P)) ? fill_q + ONE_P : fill_q;
    rd_ptr_d  = rd_ptr_q;
    tap_d     = tap_q;
    pend_d    = pend_q;
    start_run = 1'b0;

    unique case (state_q)
      IDLE, FILL: begin
        // fill_d already reflects this sample, so a saturated counter and
        // the sample that completes the fill both start a run.
        if (smpl_valid) begin
          if (fill_d == TAPS_P) start_run = 1'b1;
          else                  state_d   = FILL;
        end
      end
      RUN: begin
        rd_ptr_d = rd_ptr_q + ONE_P;
        tap_d    = tap_q + ONE_P;
        if (smpl_valid) pend_d = 1'b1;
        if (tap_q == TAPS_P) state_d = CAPT;
      end
      CAPT: begin
        // A sample arriving in CAPT starts the next run directly.
        if (pend_q || smpl_valid) start_run = 1'b1;
        else                      state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Point at the oldest sample, counting the one written this cycle.
    if (start_run) begin
      state_d  = RUN;
      rd_ptr_d = wr_ptr_d - TAPS_P;
      tap_d    = '0;
      pend_d   = 1'b0;
    end
  end

  // State and output registers; outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      fill_q   <= '0;
      pend_q   <= 1'b0;
      seq_q    <= 1'b0;
      capt_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tap_q    <= tap_d;
      fill_q   <= fill_d;
      pend_q   <= pend_d;
      seq_q    <= (state_d == RUN);
      capt_q   <= (state_d == CAPT);
      busy_q   <= (state_d == RUN) || (state_d == CAPT);
    end
  end

`ifdef FILT_SEQ_OVR_EN
  logic [7:0] ovr_q;

  assign ovr_cnt = ovr_q;

  // pend_q is only ever set in RUN/CAPT, so a sample seen with it set is a lost start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 8'd0;
    end else if (smpl_valid && pend_q && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end
`endif

endmodule
